clink_frame_arb: RTL and testbench
==================================

Name: clink_frame_arb

Overview:
Parametrised N-channel C-LINK receive aggregator for the station controller.
- Buffers frames per channel and round-robin arbitrates complete frames onto one byte stream toward M-NET.
- Prefixes each frame with a station/rack/channel header.
- Generalises the fixed six-channel station wiring to CH_NUM channels, with frame-level buffering, overflow recovery and fair arbitration.

Parameters:
CH_NUM, 6, number of C-LINK channels (1..16)
DW, 8, data byte width
FIFO_AW, 6, per-channel FIFO address width (depth = 2**FIFO_AW entries)
STAT, 8'h00, station ID placed in header byte 0
RACK, 4'h0, rack ID placed in header byte 1 [7:4]

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset, asynchronous, active-high
i_rx_data  in  CH_NUM*DW  per-channel payload byte; channel k at [k*DW +: DW]
i_rx_valid  in  CH_NUM  byte strobe per channel
i_rx_sof  in  CH_NUM  first byte of frame, qualified by valid
i_rx_eof  in  CH_NUM  last byte of frame, qualified by valid
o_tx_data  out  DW  aggregated output byte
o_tx_valid  out  1  output byte valid
o_tx_sof  out  1  first header byte
o_tx_eof  out  1  last byte of frame
i_tx_ready  in  1  downstream accept
o_ovf  out  CH_NUM  sticky per-channel frame-drop flag
i_ovf_clr  in  1  clears all o_ovf bits

Behaviour:
- Reset: all FIFOs empty, frame counters 0, FSM IDLE, round-robin pointer 0. Outputs o_tx_valid, o_tx_sof, o_tx_eof, o_tx_data and o_ovf are all 0.
- FIFO entry is {eof, data}, DW+1 bits.
- Each channel keeps wr_ptr, frm_start_ptr, rd_ptr and frm_cnt (FIFO_AW+1 bits).
- Write path, per channel, each cycle:
  - valid & sof while a partial frame is open: rewind wr_ptr to frm_start_ptr (abort), then write the sof byte.
  - valid & FIFO full: drop the whole partial frame (wr_ptr := frm_start_ptr), set o_ovf[k], ignore bytes until the next sof.
  - valid & eof accepted: frm_start_ptr := wr_ptr+1, frm_cnt++.
  - A byte without a preceding sof is discarded.
- Channel k is eligible when frm_cnt[k] > 0.
- Only complete frames are ever read.
- eof write and eof read on the same channel in the same cycle leave frm_cnt unchanged.
- FSM:
  - IDLE: if any channel is eligible, grant the first eligible channel at or after rr_ptr (wrap modulo CH_NUM), go to HDR0.
  - HDR0: o_tx_data=STAT, o_tx_sof=1.
  - HDR1: o_tx_data={RACK, grant[3:0]}.
  - DATA: stream FIFO bytes. The byte carrying the stored eof asserts o_tx_eof. On its acceptance: frm_cnt--, rr_ptr := grant+1, return to IDLE.
- Handshake: a byte transfers when o_tx_valid & i_tx_ready. While o_tx_valid=1 and i_tx_ready=0, data, sof and eof are held stable. o_tx_valid never drops mid-frame: the frame is complete in the FIFO, so no bubbles occur.
- Latency: the first header byte is valid 1 cycle after eligibility is seen in IDLE. Back-to-back frames insert exactly one IDLE cycle.
- FIFO read is registered (1-cycle read latency), prefetched during HDR1 so DATA runs at full rate.
- Pointer arithmetic wraps modulo 2**FIFO_AW. Full means (wr-rd) == 2**FIFO_AW, using extra MSB.
- A frame longer than FIFO depth can never complete; it is dropped via the full rule and o_ovf is set.
- i_ovf_clr and a new overflow in the same cycle: the overflow wins (bit stays 1).

Optional Feature:
CLINK_ARB_CRC_EN
- Defined: after the last payload byte, a CRC state emits one CRC-8 byte over header and payload (poly 0x07, init 0x00, MSB-first). o_tx_eof moves to the CRC byte; the payload eof byte has o_tx_eof=0.
- Undefined: no CRC state, frame = 2 header bytes + payload, as above.

Decomposition:
- Package clink_arb_pkg holds:
  - FSM state encoding (IDLE, HDR0, HDR1, DATA, CRC)
  - header length constant 2
  - CRC8_POLY = 8'h07
  - CRC8 next-byte function
- Sub-module clink_frame_fifo: single-channel FIFO with frame rollback, frm_cnt and overflow flag. Instantiated CH_NUM times via generate.
- Arbiter/FSM stays in the top module.

Test Plan:
- Ch2 sends a 4-byte frame 11 22 33 44, ready=1 -> out A: 00 (sof), 02, 11 22 33 44 (eof on 44); with CRC_EN, A is followed by one CRC byte carrying eof; o_ovf=0.
- Ch0, ch3, ch5 each complete one frame in the same cycle, rr_ptr=4 -> grant order 5, 0, 3, each frame separated by one idle cycle.
- Ch1 frame with i_tx_ready toggling 1,0,0,1 during DATA -> each byte held stable while stalled; no byte lost or duplicated.
- FIFO_AW=3, ch4 sends a 10-byte frame, then a 3-byte frame -> o_ovf[4]=1, first frame absent from output, second frame output intact; i_ovf_clr clears o_ovf[4].
- Ch0 sends sof AA BB, then a new sof CC DD eof -> only CC DD is output.
- Assert i_rst during DATA of a frame -> o_tx_valid=0 immediately; after release no residual bytes are output and all frm_cnt=0.

Source files
------------

// File: rtl/clink_arb_pkg.sv
// Shared types, constants and CRC-8 helper for the C-LINK frame aggregator.
package clink_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_DATA,
    ST_CRC
  } arb_state_e;

  localparam int         HDR_LEN   = 2;
  localparam logic [7:0] CRC8_POLY = 8'h07;

  // MSB-first CRC-8 advanced by one byte.
  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] dat);
    logic [7:0] c;
    c = crc ^ dat;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/clink_frame_fifo.sv
// Single-channel frame FIFO with partial-frame rollback, complete-frame count and sticky overflow.
// Read data registered one cycle after i_rd_pop; writes never stall, an overflowing frame is dropped.
module clink_frame_fifo #(
  parameter int DW      = 8,
  parameter int FIFO_AW = 6
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_vld,
  input  logic          i_wr_sof,
  input  logic          i_wr_eof,
  input  logic [DW-1:0] i_wr_dat,
  input  logic          i_rd_pop,
  input  logic          i_frm_done,
  output logic [DW:0]   o_rd_dat,
  output logic          o_frm_avail,
  input  logic          i_ovf_clr,
  output logic          o_ovf
);

  localparam int            PW    = FIFO_AW + 1;
  localparam logic [PW-1:0] DEPTH = PW'(1) << FIFO_AW;

  logic [DW:0]   mem_q [1 << FIFO_AW];
  logic [DW:0]   dout_q;
  logic [PW-1:0] wr_q, wr_d, start_q, start_d, rd_q, cnt_q, cnt_d, base;
  logic          open_q, open_d, ovf_q, ovf_d, we, frm_inc;

  always_comb begin
    wr_d    = wr_q;
    start_d = start_q;
    open_d  = open_q;
    base    = wr_q;
    we      = 1'b0;
    frm_inc = 1'b0;
    ovf_d   = ovf_q & ~i_ovf_clr;
    if (i_wr_vld && (i_wr_sof || open_q)) begin
      // A sof always restarts at the frame base, which discards any open partial frame.
      base = i_wr_sof ? start_q : wr_q;
      if (PW'(base - rd_q) == DEPTH) begin
        wr_d   = start_q;
        open_d = 1'b0;
        ovf_d  = 1'b1;
      end else begin
        we     = 1'b1;
        wr_d   = base + PW'(1);
        open_d = ~i_wr_eof;
        if (i_wr_eof) begin
          start_d = base + PW'(1);
          frm_inc = 1'b1;
        end
      end
    end
  end

  always_comb begin
    case ({frm_inc, i_frm_done})
      2'b10:   cnt_d = cnt_q + PW'(1);
      2'b01:   cnt_d = cnt_q - PW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (we) mem_q[base[FIFO_AW-1:0]] <= {i_wr_eof, i_wr_dat};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_q    <= '0;
      start_q <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      open_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      wr_q    <= wr_d;
      start_q <= start_d;
      cnt_q   <= cnt_d;
      open_q  <= open_d;
      ovf_q   <= ovf_d;
      if (i_rd_pop) begin
        dout_q <= mem_q[rd_q[FIFO_AW-1:0]];
        rd_q   <= rd_q + PW'(1);
      end
    end
  end

  assign o_rd_dat    = dout_q;
  assign o_frm_avail = (cnt_q != '0);
  assign o_ovf       = ovf_q;

endmodule

// File: rtl/clink_frame_arb.sv
// CH_NUM-channel C-LINK aggregator: buffers frames, round-robins complete ones out with a 2-byte header.
// Header valid one cycle after a frame is seen complete; holds output on !i_tx_ready. CLINK_ARB_CRC_EN appends CRC-8.
module clink_frame_arb
  import clink_arb_pkg::*;
#(
  parameter int         CH_NUM  = 6,
  parameter int         DW      = 8,
  parameter int         FIFO_AW = 6,
  parameter logic [7:0] STAT    = 8'h00,
  parameter logic [3:0] RACK    = 4'h0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [CH_NUM*DW-1:0] i_rx_data,
  input  logic [CH_NUM-1:0]    i_rx_valid,
  input  logic [CH_NUM-1:0]    i_rx_sof,
  input  logic [CH_NUM-1:0]    i_rx_eof,
  output logic [DW-1:0]        o_tx_data,
  output logic                 o_tx_valid,
  output logic                 o_tx_sof,
  output logic                 o_tx_eof,
  input  logic                 i_tx_ready,
  output logic [CH_NUM-1:0]    o_ovf,
  input  logic                 i_ovf_clr
);

  logic [CH_NUM-1:0] avail, pop, done;
  logic [DW:0]       rd_dat [CH_NUM];
  logic [DW:0]       cur;
  arb_state_e        state_q, state_d;
  logic [3:0]        grant_q, grant_d, rr_q, rr_d, rr_next;
  logic [3:0]        pick, hi, lo;
  logic              pick_vld, hi_vld, accept, pop_any, done_any;
  logic [7:0]        hdr1;
`ifdef CLINK_ARB_CRC_EN
  logic [7:0]        crc_q, crc_d;
`endif

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    clink_frame_fifo #(
      .DW      (DW),
      .FIFO_AW (FIFO_AW)
    ) u_fifo (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_wr_vld    (i_rx_valid[k]),
      .i_wr_sof    (i_rx_sof[k]),
      .i_wr_eof    (i_rx_eof[k]),
      .i_wr_dat    (i_rx_data[k*DW +: DW]),
      .i_rd_pop    (pop[k]),
      .i_frm_done  (done[k]),
      .o_rd_dat    (rd_dat[k]),
      .o_frm_avail (avail[k]),
      .i_ovf_clr   (i_ovf_clr),
      .o_ovf       (o_ovf[k])
    );
    assign pop[k]  = pop_any  && (grant_q == 4'(k));
    assign done[k] = done_any && (grant_q == 4'(k));
  end

  always_comb begin
    cur = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      if (grant_q == 4'(k)) cur = rd_dat[k];
    end
  end

  // Descending scan: lo ends as the lowest eligible channel, hi as the lowest at or after rr_q.
  always_comb begin
    hi_vld   = 1'b0;
    pick_vld = 1'b0;
    hi       = '0;
    lo       = '0;
    for (int k = CH_NUM - 1; k >= 0; k--) begin
      if (avail[k]) begin
        pick_vld = 1'b1;
        lo       = 4'(k);
        if (4'(k) >= rr_q) begin
          hi_vld = 1'b1;
          hi     = 4'(k);
        end
      end
    end
    pick = hi_vld ? hi : lo;
  end

  assign hdr1    = {RACK, grant_q};
  assign accept  = o_tx_valid & i_tx_ready;
  assign rr_next = (grant_q == 4'(CH_NUM - 1)) ? 4'd0 : grant_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    pop_any  = 1'b0;
    done_any = 1'b0;
`ifdef CLINK_ARB_CRC_EN
    crc_d    = crc_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_d = pick;
          state_d = ST_HDR0;
        end
      end
      ST_HDR0: begin
        if (accept) begin
          state_d = ST_HDR1;
`ifdef CLINK_ARB_CRC_EN
          crc_d   = crc8_next(8'h00, STAT);
`endif
        end
      end
      ST_HDR1: begin
        // Prefetch the first payload byte so DATA runs without bubbles.
        if (accept) begin
          state_d = ST_DATA;
          pop_any = 1'b1;
`ifdef CLINK_ARB_CRC_EN
          crc_d   = crc8_next(crc_q, hdr1);
`endif
        end
      end
      ST_DATA: begin
        if (accept) begin
`ifdef CLINK_ARB_CRC_EN
          crc_d = crc8_next(crc_q, 8'(cur[DW-1:0]));
`endif
          if (cur[DW]) begin
            done_any = 1'b1;
            rr_d     = rr_next;
`ifdef CLINK_ARB_CRC_EN
            state_d  = ST_CRC;
`else
            state_d  = ST_IDLE;
`endif
          end else begin
            pop_any = 1'b1;
          end
        end
      end
`ifdef CLINK_ARB_CRC_EN
      ST_CRC: begin
        if (accept) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_tx_valid = (state_q != ST_IDLE);
    o_tx_sof   = (state_q == ST_HDR0);
    o_tx_eof   = 1'b0;
    o_tx_data  = '0;
    case (state_q)
      ST_HDR0: o_tx_data = DW'(STAT);
      ST_HDR1: o_tx_data = DW'(hdr1);
      ST_DATA: begin
        o_tx_data = cur[DW-1:0];
`ifndef CLINK_ARB_CRC_EN
        o_tx_eof  = cur[DW];
`endif
      end
`ifdef CLINK_ARB_CRC_EN
      ST_CRC: begin
        o_tx_data = DW'(crc_q);
        o_tx_eof  = 1'b1;
      end
`endif
      default: o_tx_data = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
`ifdef CLINK_ARB_CRC_EN
      crc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
`ifdef CLINK_ARB_CRC_EN
      crc_q   <= crc_d;
`endif
    end
  end

endmodule

// File: tb/tb_clink_frame_arb.sv
// Bench for clink_frame_arb: directed scenarios plus randomized rounds against a frame-level model.
module tb_clink_frame_arb;

  localparam int         CH   = 6;
  localparam int         DW   = 8;
  localparam int         AW   = 3;
  localparam logic [7:0] STAT = 8'h5A;
  localparam logic [3:0] RACK = 4'h3;

  logic              clk, rst;
  logic [CH*DW-1:0]  rx_data;
  logic [CH-1:0]     rx_valid, rx_sof, rx_eof, ovf;
  logic [DW-1:0]     tx_data;
  logic              tx_valid, tx_sof, tx_eof, tx_ready, ovf_clr;

  int checks = 0;
  int errors = 0;

  clink_frame_arb #(
    .CH_NUM (CH), .DW (DW), .FIFO_AW (AW), .STAT (STAT), .RACK (RACK)
  ) dut (
    .i_clk (clk), .i_rst (rst),
    .i_rx_data (rx_data), .i_rx_valid (rx_valid), .i_rx_sof (rx_sof), .i_rx_eof (rx_eof),
    .o_tx_data (tx_data), .o_tx_valid (tx_valid), .o_tx_sof (tx_sof), .o_tx_eof (tx_eof),
    .i_tx_ready (tx_ready), .o_ovf (ovf), .i_ovf_clr (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- monitor: accepted bytes packed as {sof, eof, data} ----------------
  logic [9:0] obs_q[$];
  int         obs_cyc[$];
  int         cyc = 0, eof_cnt = 0, stab_err = 0, bubble_err = 0;
  logic       prev_stall = 1'b0, in_frame = 1'b0;
  logic [9:0] prev_pk = '0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_stall = 1'b0;
      in_frame   = 1'b0;
    end else begin
      if (prev_stall && (!tx_valid || {tx_sof, tx_eof, tx_data} !== prev_pk)) stab_err++;
      if (in_frame && !tx_valid) bubble_err++;
      if (tx_valid && tx_ready) begin
        obs_q.push_back({tx_sof, tx_eof, tx_data});
        obs_cyc.push_back(cyc);
        in_frame = !tx_eof;
        if (tx_eof) eof_cnt++;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_pk    = {tx_sof, tx_eof, tx_data};
    end
  end

  // ---------------- ready driver ----------------
  int         rdy_mode = 0;
  int         pat_i = 0;
  logic [3:0] rdy_pat = 4'b1001;
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1:       tx_ready = ($urandom_range(0, 3) != 0);
        2:       begin tx_ready = rdy_pat[pat_i % 4]; pat_i++; end
        default: tx_ready = 1'b1;
      endcase
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] pay [CH][16];
  int         plen [CH];
  logic [9:0] exp_q[$];
  int         rr_m = 0;

  function automatic logic [7:0] ref_crc(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    logic       fb;
    r = c;
    for (int b = 7; b >= 0; b--) begin
      fb = r[7] ^ d[b];
      r  = {r[6:0], 1'b0};
      if (fb) r = r ^ 8'h07;
    end
    return r;
  endfunction

  task automatic expect_frame(input int ch);
    logic [7:0] h1, c;
    h1 = {RACK, 4'(ch)};
    exp_q.push_back({2'b10, STAT});
    exp_q.push_back({2'b00, h1});
    c = ref_crc(ref_crc(8'h00, STAT), h1);
    for (int i = 0; i < plen[ch]; i++) begin
`ifdef CLINK_ARB_CRC_EN
      exp_q.push_back({2'b00, pay[ch][i]});
`else
      exp_q.push_back({1'b0, (i == plen[ch] - 1), pay[ch][i]});
`endif
      c = ref_crc(c, pay[ch][i]);
    end
`ifdef CLINK_ARB_CRC_EN
    exp_q.push_back({2'b01, c});
`endif
    rr_m = (ch + 1) % CH;
  endtask

  // Frames that become complete together leave in round-robin order from rr_m.
  task automatic expect_rr(input logic [CH-1:0] mask);
    int start, idx;
    start = rr_m;
    for (int i = 0; i < CH; i++) begin
      idx = (start + i) % CH;
      if (mask[idx]) expect_frame(idx);
    end
  endtask

  task automatic clear_sb;
    obs_q.delete();
    obs_cyc.delete();
    exp_q.delete();
    eof_cnt    = 0;
    stab_err   = 0;
    bubble_err = 0;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle_in;
    @(posedge clk); #1;
    rx_valid = '0; rx_sof = '0; rx_eof = '0;
  endtask

  task automatic drive(input int ch, input logic sof, input logic eof, input logic [7:0] d);
    @(posedge clk); #1;
    rx_valid = '0; rx_sof = '0; rx_eof = '0;
    rx_valid[ch] = 1'b1; rx_sof[ch] = sof; rx_eof[ch] = eof;
    rx_data[ch*DW +: DW] = d;
  endtask

  // Sends pay[] on every channel in mask with all eof bytes landing on the same edge.
  task automatic send_aligned(input logic [CH-1:0] mask);
    int maxl, st, idx;
    maxl = 0;
    for (int ch = 0; ch < CH; ch++) if (mask[ch] && plen[ch] > maxl) maxl = plen[ch];
    for (int t = 0; t < maxl; t++) begin
      @(posedge clk); #1;
      rx_valid = '0; rx_sof = '0; rx_eof = '0;
      for (int ch = 0; ch < CH; ch++) begin
        st = maxl - plen[ch];
        if (mask[ch] && t >= st) begin
          idx = t - st;
          rx_valid[ch] = 1'b1;
          rx_sof[ch]   = (idx == 0);
          rx_eof[ch]   = (idx == plen[ch] - 1);
          rx_data[ch*DW +: DW] = pay[ch][idx];
        end
      end
    end
    idle_in();
  endtask

  task automatic wait_frames(input int n, input string name);
    int t;
    t = 0;
    while (eof_cnt < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (eof_cnt < n) begin
      errors++;
      $display("FAIL %s_timeout frames seen %0d required %0d", name, eof_cnt, n);
    end
    repeat (6) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", tx_valid); end
    checks++; if (tx_sof !== 1'b0) begin errors++; $display("FAIL reset_sof got %b exp 0", tx_sof); end
    checks++; if (tx_eof !== 1'b0) begin errors++; $display("FAIL reset_eof got %b exp 0", tx_eof); end
    checks++; if (tx_data !== '0) begin errors++; $display("FAIL reset_data got %h exp 00", tx_data); end
    checks++; if (ovf !== '0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid got %b exp 0", tx_valid); end
  endtask

  task automatic test_single_frame;
    clear_sb();
    plen[2] = 4;
    pay[2][0] = 8'h11; pay[2][1] = 8'h22; pay[2][2] = 8'h33; pay[2][3] = 8'h44;
    expect_rr(6'b000100);
    send_aligned(6'b000100);
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL latency_early valid got %b exp 0", tx_valid); end
    @(negedge clk);
    checks++;
    if ({tx_valid, tx_sof, tx_data} !== {2'b11, STAT}) begin
      errors++; $display("FAIL latency_hdr0 got v%b s%b %h exp v1 s1 %h", tx_valid, tx_sof, tx_data, STAT);
    end
    wait_frames(1, "single");
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL single_len got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_byte%0d got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (ovf !== '0) begin errors++; $display("FAIL single_ovf got %b exp 0", ovf); end
  endtask

  task automatic test_rr_order;
    clear_sb();
    plen[3] = 1; pay[3][0] = 8'h31;
    expect_rr(6'b001000);
    send_aligned(6'b001000);
    wait_frames(1, "rr_prime");
    clear_sb();
    plen[0] = 3; pay[0][0] = 8'hA0; pay[0][1] = 8'hA1; pay[0][2] = 8'hA2;
    plen[3] = 2; pay[3][0] = 8'hB0; pay[3][1] = 8'hB1;
    plen[5] = 4; pay[5][0] = 8'hC0; pay[5][1] = 8'hC1; pay[5][2] = 8'hC2; pay[5][3] = 8'hC3;
    expect_rr(6'b101001);
    send_aligned(6'b101001);
    wait_frames(3, "rr");
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rr_len got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rr_byte%0d got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    for (int i = 0; i + 1 < obs_q.size(); i++) begin
      if (obs_q[i][8]) begin
        checks++;
        if (obs_cyc[i+1] != obs_cyc[i] + 2) begin
          errors++; $display("FAIL rr_gap after byte%0d got %0d cycles exp 2", i, obs_cyc[i+1] - obs_cyc[i]);
        end
      end
    end
    checks++; if (bubble_err != 0) begin errors++; $display("FAIL rr_bubbles got %0d exp 0", bubble_err); end
  endtask

  task automatic test_stall;
    clear_sb();
    rdy_mode = 2;
    plen[1] = 5;
    for (int i = 0; i < 5; i++) pay[1][i] = 8'(8'h60 + i);
    expect_rr(6'b000010);
    send_aligned(6'b000010);
    wait_frames(1, "stall");
    rdy_mode = 0;
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL stall_len got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_byte%0d got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL stall_hold got %0d changes exp 0", stab_err); end
    checks++; if (bubble_err != 0) begin errors++; $display("FAIL stall_bubbles got %0d exp 0", bubble_err); end
  endtask

  task automatic test_overflow;
    clear_sb();
    plen[4] = 10;
    for (int i = 0; i < 10; i++) pay[4][i] = 8'(8'h80 + i);
    send_aligned(6'b010000);
    repeat (10) @(negedge clk);
    checks++; if (ovf !== 6'b010000) begin errors++; $display("FAIL ovf_set got %b exp 010000", ovf); end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL ovf_dropped got %0d bytes exp 0", obs_q.size()); end
    plen[4] = 3; pay[4][0] = 8'hD0; pay[4][1] = 8'hD1; pay[4][2] = 8'hD2;
    expect_rr(6'b010000);
    send_aligned(6'b010000);
    wait_frames(1, "ovf");
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_len got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_byte%0d got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    @(posedge clk); #1; ovf_clr = 1'b1;
    @(posedge clk); #1; ovf_clr = 1'b0;
    @(negedge clk);
    checks++; if (ovf !== '0) begin errors++; $display("FAIL ovf_clr got %b exp 0", ovf); end
    // Clear lands on the same edge as the overflowing ninth byte.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      rx_valid = '0; rx_sof = '0; rx_eof = '0;
      rx_valid[4] = 1'b1; rx_sof[4] = (i == 0); rx_eof[4] = (i == 9);
      rx_data[4*DW +: DW] = 8'(8'h90 + i);
      ovf_clr = (i == 8);
    end
    idle_in();
    ovf_clr = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (ovf !== 6'b010000) begin errors++; $display("FAIL ovf_clr_race got %b exp 010000", ovf); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_race_out got %0d bytes exp %0d", obs_q.size(), exp_q.size()); end
    @(posedge clk); #1; ovf_clr = 1'b1;
    @(posedge clk); #1; ovf_clr = 1'b0;
  endtask

  task automatic test_abort;
    clear_sb();
    plen[0] = 2; pay[0][0] = 8'hCC; pay[0][1] = 8'hDD;
    expect_rr(6'b000001);
    drive(0, 1'b1, 1'b0, 8'hAA);
    drive(0, 1'b0, 1'b0, 8'hBB);
    drive(1, 1'b0, 1'b0, 8'hEE);
    drive(1, 1'b0, 1'b1, 8'hEF);
    drive(0, 1'b1, 1'b0, 8'hCC);
    drive(0, 1'b0, 1'b1, 8'hDD);
    idle_in();
    wait_frames(1, "abort");
    repeat (10) @(negedge clk);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL abort_len got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL abort_byte%0d got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (ovf !== '0) begin errors++; $display("FAIL abort_ovf got %b exp 0", ovf); end
  endtask

  task automatic test_reset_mid;
    int t;
    clear_sb();
    plen[3] = 6;
    for (int i = 0; i < 6; i++) pay[3][i] = 8'(8'h40 + i);
    send_aligned(6'b001000);
    t = 0;
    while (obs_q.size() < 4 && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++; if (obs_q.size() < 4) begin errors++; $display("FAIL rstmid_timeout got %0d bytes exp 4", obs_q.size()); end
    #2 rst = 1'b1;
    #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", tx_valid); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_sb();
    rr_m = 0;
    repeat (30) @(negedge clk);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rstmid_residual got %0d bytes exp 0", obs_q.size()); end
    plen[1] = 2; pay[1][0] = 8'h71; pay[1][1] = 8'h72;
    expect_rr(6'b000010);
    send_aligned(6'b000010);
    wait_frames(1, "rstmid");
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rstmid_len got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_byte%0d got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random;
    logic [CH-1:0] mask;
    int            nfr;
    rdy_mode = 1;
    for (int r = 0; r < 25; r++) begin
      clear_sb();
      mask = 6'($urandom_range(1, (1 << CH) - 1));
      nfr  = 0;
      for (int ch = 0; ch < CH; ch++) begin
        plen[ch] = $urandom_range(1, 1 << AW);
        for (int i = 0; i < plen[ch]; i++) pay[ch][i] = 8'($urandom);
        if (mask[ch]) nfr++;
      end
      expect_rr(mask);
      send_aligned(mask);
      wait_frames(nfr, "rand");
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_len got %0d exp %0d", r, obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_byte%0d got %h exp %h", r, i, obs_q[i], exp_q[i]); end
      end
      checks++; if (stab_err != 0 || bubble_err != 0) begin errors++; $display("FAIL rand%0d_flow got hold %0d bubble %0d exp 0 0", r, stab_err, bubble_err); end
    end
    rdy_mode = 0;
    checks++; if (ovf !== '0) begin errors++; $display("FAIL rand_ovf got %b exp 0", ovf); end
  endtask

  initial begin
    rst = 1'b1; ovf_clr = 1'b0;
    rx_data = '0; rx_valid = '0; rx_sof = '0; rx_eof = '0;
    for (int ch = 0; ch < CH; ch++) plen[ch] = 0;
    test_reset();
    test_single_frame();
    test_rr_order();
    test_stall();
    test_overflow();
    test_abort();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
